// File: rtl/sort_reorder_ctrl.sv
// -----------------------------------------------------------------------------
// sort_reorder_ctrl
//
// Address/enable controller for the 32-point FFT output reorder buffer. The
// buffer is a ping-pong pair of N-entry banks in an external sync-read RAM
// (1-cycle read latency). FFT samples are written in natural order into the
// bank being filled. Each completed bank is then read back in bit-reversed
// address order, which yields a natural-order spectrum. Only addresses,
// strobes and bank selects are produced here; the data path is external.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   in_valid   in   FFT output sample present this cycle
//   out_stall  in   downstream not ready; pauses the read side
//   ovf_clr    in   synchronous clear of the sticky overflow flag
//   wr_en      out  write strobe to reorder RAM
//   wr_bank    out  bank being filled
//   wr_addr    out  natural-order write address
//   rd_en      out  read strobe to reorder RAM
//   rd_bank    out  bank being drained
//   rd_addr    out  bit-reversed read address
//   out_valid  out  RAM read data valid (rd_en delayed one cycle)
//   out_last   out  with out_valid: last sample of the frame
//   overflow   out  sticky: a sample was dropped
//   busy       out  any frame in flight
//   state_dbg  out  read FSM state (0 = IDLE, 1 = READ)
//
// Handshake: in_valid is a one-way push with no back-pressure; a sample is
// taken when wr_en is high and dropped (flagging overflow) when in_valid is
// high but the target bank is still full. out_stall is a level that freezes
// the read side for as long as it is high; rd_en is low in those cycles.
// -----------------------------------------------------------------------------
module sort_reorder_ctrl #(
    parameter int N     = 32,
    parameter int LOG2N = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             out_stall,
    input  logic             ovf_clr,
    output logic             wr_en,
    output logic             wr_bank,
    output logic [LOG2N-1:0] wr_addr,
    output logic             rd_en,
    output logic             rd_bank,
    output logic [LOG2N-1:0] rd_addr,
    output logic             out_valid,
    output logic             out_last,
    output logic             overflow,
    output logic             busy,
    output logic             state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             rd_release;
    logic             busy_w;
    logic             drop;
    logic             wr_last;
    logic             rd_last;

    assign wr_last = (wr_cnt == LOG2N'(N-1));
    assign rd_last = (rd_cnt == LOG2N'(N-1));

    // ---------------------------------------------------------------------
    // Read FSM: next state, read strobe, release of the drained bank
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        rd_en      = 1'b0;
        rd_release = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                rd_en = ~out_stall;
                if (~out_stall && rd_last) begin
                    rd_release = 1'b1;
                    // Other bank already full: continue without a gap.
                    if (!full[~rd_bank]) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A bank released this cycle is writable in the same cycle. The writer
    // is then at address 0 while the reader is at N-1, so no collision.
    assign busy_w  = full[wr_bank] & ~rd_release;
    assign wr_en   = in_valid & ~busy_w;
    assign drop    = in_valid & busy_w;
    assign wr_addr = wr_cnt;

    // Bit-reversed read address: bit i takes rd_cnt bit LOG2N-1-i.
    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < LOG2N; i++) begin
            rd_addr[i] = rd_cnt[LOG2N-1-i];
        end
    end

    // Set (writer bank) and clear (reader bank) never hit the same bank in
    // one cycle, so applying both in sequence is safe.
    always_comb begin
        full_nxt = full;
        if (rd_release) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_en && wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    assign busy      = (state == READ) | full[0] | full[1] | (wr_cnt != '0);
    assign state_dbg = (state == READ);

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            full    <= 2'b00;
        end else begin
            full <= full_nxt;
            if (wr_en) begin
                // N is a power of two, so the increment wraps N-1 -> 0.
                wr_cnt <= wr_cnt + LOG2N'(1);
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            if (state == IDLE) begin
                rd_cnt <= '0;
            end else if (rd_en) begin
                rd_cnt <= rd_cnt + LOG2N'(1);
            end
            if (rd_release) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Output pipeline matches the one-cycle RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= rd_en;
            out_last  <= rd_en & rd_last;
        end
    end

    // A drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
